fir_requantizer: RTL
====================

Name: fir_requantizer

Overview:
- Sits directly downstream of the 15-tap FIR, upstream of the I2S2 transmit path.
- Takes the FIR's wide full-precision accumulator output and rounds it back to the 24-bit audio sample format: round-half-up, arithmetic shift, saturation.
- Presents the result on an AXI-Stream master with a small output FIFO, so downstream backpressure never corrupts in-flight samples.
- Counts clipped samples for debug.

Parameters:
- IN_WIDTH, 52: input sample width (48-bit product + 4 growth bits).
- OUT_WIDTH, 24: output sample width.
- SHIFT, 23: right-shift amount (Q1.23 coefficients), 1..IN_WIDTH-OUT_WIDTH.
- FIFO_DEPTH, 4: output FIFO entries, power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  IN_WIDTH  signed FIR output sample.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tlast  in  1  end-of-frame / right-channel marker, passed through.
- s_axis_tready  out  1  block can accept a sample this cycle.
- m_axis_tdata  out  OUT_WIDTH  signed requantized sample.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tlast  out  1  tlast of the sample currently presented.
- m_axis_tkeep  out  3  byte enables, constant 3'b111.
- m_axis_tready  in  1  downstream accepts.
- sat_flag  out  1  tlast-aligned sideband: current output sample was clipped.
- sat_count  out  16  number of clipped samples, saturates at 0xFFFF.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - stage valids, FIFO pointers and count, sat_count;
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, sat_flag=0;
  - s_axis_tready=0 while reset is asserted.
- Reset asserted mid-operation discards all in-flight and buffered samples. No partial output appears after release.
- Input handshake:
  - A transfer occurs when s_axis_tvalid & s_axis_tready.
  - tdata and tlast are captured into stage A.
  - Input tkeep is not used.
- Stage A (1 cycle): sum = sign-extended tdata + 2^(SHIFT-1), computed at IN_WIDTH+1 bits so it never overflows.
- Stage B (1 cycle):
  - q = sum >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_WIDTH-1)-1, output 0x7FFFFF and set sat=1.
  - If q < -2^(OUT_WIDTH-1), output 0x800000 and set sat=1.
  - Otherwise output the low OUT_WIDTH bits of q with sat=0.
- Stage B output is written into the FIFO together with tlast and sat.
- Stages A and B always advance; they never stall. Flow control is by credit only.
- Occupancy = fifo_count + valid_A + valid_B, all taken from registers.
- s_axis_tready = (occupancy < FIFO_DEPTH) after reset release. It has no combinational path from m_axis_tready or s_axis_tvalid.
- FIFO output:
  - The head entry drives m_axis_tdata, m_axis_tlast and sat_flag.
  - m_axis_tvalid = (fifo_count != 0).
  - The head pops when m_axis_tvalid & m_axis_tready.
  - Output holds stable while valid and not ready (AXI-Stream rule).
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- FIFO full: guaranteed never to overflow by the credit rule. A push into a full FIFO is a design error; the bench asserts it never happens.
- Latency: input handshake in cycle N, FIFO write at the end of N+2, m_axis_tvalid high in cycle N+3 when the FIFO was empty.
- Throughput: one sample per clock when m_axis_tready stays high.
- sat_count increments by 1 on each FIFO write with sat=1, holding at 0xFFFF.
- Ordering of data, tlast and sat is preserved exactly.

Test Plan:
- Rounding, SHIFT=23:
  - inputs 0x400000 (2^22), 0x3FFFFF, -0x400000, -0x400001, 0x7FFFFF800000
  - required outputs 0x000001, 0x000000, 0x000000, 0xFFFFFF, 0x7FFFFF; sat=0 on all.
- Saturation:
  - inputs 2^46, -2^47, 2^46-2^22-1
  - required outputs 0x7FFFFF (sat=1), 0x800000 (sat=1), 0x7FFFFF (sat=0)
  - sat_count = 2 afterwards.
- Latency/throughput: m_axis_tready=1, 8 back-to-back samples with tlast on the 2nd and 8th.
  - First m_axis_tvalid exactly 3 cycles after the first handshake, then 8 consecutive outputs, tlast on outputs 2 and 8.
- Backpressure: m_axis_tready=0, drive 6 valid samples.
  - Exactly 4 accepted; s_axis_tready low after the 4th.
  - m_axis_tdata stable.
  - Release ready: the 4 outputs drain in order, then the remaining 2 are accepted.
- Random ready/valid for 10k samples vs. a reference model: bit-exact data, tlast and sat in order; no FIFO overflow.
- Reset asserted with 3 samples buffered: m_axis_tvalid=0 and sat_count=0 immediately (asynchronously); the first output after release is the first new input.

Source files
------------

// File: rtl/fir_requantizer.sv
// Requantizes the wide FIR accumulator to the 24-bit sample format (round-half-up,
// arithmetic shift, saturate) and presents it on an AXI-Stream master via a small FIFO.
module fir_requantizer #(
   parameter int IN_WIDTH   = 52,
   parameter int OUT_WIDTH  = 24,
   parameter int SHIFT      = 23,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IN_WIDTH-1:0]  s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic [OUT_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   output logic [2:0]           m_axis_tkeep,
   input  logic                 m_axis_tready,
   output logic                 sat_flag,
   output logic [15:0]          sat_count
);

   localparam int STAGES = 2;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int OCC_W  = CNT_W + 1;
   localparam logic [IN_WIDTH:0] RND = (IN_WIDTH+1)'(1) << (SHIFT-1);

   typedef struct packed {
      logic [OUT_WIDTH-1:0] data;
      logic                 last;
      logic                 sat;
   } entry_t;

   logic [STAGES-1:0]        vld_pipe;
   logic signed [IN_WIDTH:0] sum_a;
   logic                     last_a;
   logic signed [IN_WIDTH:0] q;
   logic                     in_range;
   entry_t                   ent_q, ent_b, head;

   entry_t                   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         fifo_count;
   logic [OCC_W-1:0]         occupancy;
   logic                     in_fire, push, pop;

   // Credit-based flow control: the pipeline never stalls, so everything already
   // in flight must have a guaranteed FIFO slot before a new sample is accepted.
   assign occupancy     = OCC_W'(fifo_count) + OCC_W'(vld_pipe[0]) + OCC_W'(vld_pipe[1]);
   assign s_axis_tready = !reset && (occupancy < OCC_W'(FIFO_DEPTH));
   assign in_fire       = s_axis_tvalid & s_axis_tready;
   assign push          = vld_pipe[1];
   assign pop           = m_axis_tvalid & m_axis_tready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[0], in_fire};
   end

   // Stage A: add the half-LSB at one extra bit so the rounding add cannot overflow.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         sum_a  <= {s_axis_tdata[IN_WIDTH-1], s_axis_tdata} + RND;
         last_a <= s_axis_tlast;
      end
   end

   // Stage B: in range iff all bits from the output sign bit upward agree.
   always_comb begin
      q          = sum_a >>> SHIFT;
      in_range   = (&q[IN_WIDTH:OUT_WIDTH-1]) | ~(|q[IN_WIDTH:OUT_WIDTH-1]);
      ent_q.last = last_a;
      ent_q.sat  = !in_range;
      if (in_range)        ent_q.data = q[OUT_WIDTH-1:0];
      else if (q[IN_WIDTH]) ent_q.data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                 ent_q.data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk) begin
      if (vld_pipe[0]) ent_b <= ent_q;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ent_b;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         sat_count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push && ent_b.sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
      end
   end

   // Outputs are forced to zero when empty so reset and idle look identical downstream.
   assign head          = mem[rd_ptr];
   assign m_axis_tvalid = (fifo_count != '0);
   assign m_axis_tdata  = m_axis_tvalid ? head.data : '0;
   assign m_axis_tlast  = m_axis_tvalid & head.last;
   assign sat_flag      = m_axis_tvalid & head.sat;
   assign m_axis_tkeep  = 3'b111;

endmodule
